// File: rtl/instr_encoder.sv
// Field-level RV32 instruction encoder that validates R/LOAD/STORE requests
// and writes the packed words to sequential instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              word_done,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [1:0] KIND_R     = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;
  logic [31:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              word_done_q, word_done_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;

  logic        full_w;
  logic        accept;
  logic        imm_bad;
  logic        f7_bad;
  logic [31:0] enc_word;

  assign full_w   = (count_q == DEPTH_CNT);
  assign in_ready = (state_q == S_IDLE) & ~full_w & ~flush;
  assign accept   = in_valid & in_ready;

  // A 12-bit signed immediate fits only if bits 31..11 are a pure sign extension.
  assign imm_bad = ~((&imm_q[31:11]) | ~(|imm_q[31:11]));
  assign f7_bad  = (f7_q != 7'b0000000) && (f7_q != 7'b0100000);

  always_comb begin
    enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
    case (kind_q)
      KIND_LOAD:  enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
      KIND_STORE: enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
      default:    enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    f3_d        = f3_q;
    f7_d        = f7_q;
    imm_d       = imm_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_done_d = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          kind_d  = in_kind;
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          f3_d    = in_funct3;
          f7_d    = in_funct7;
          imm_d   = in_imm;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (kind_q == 2'b11) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b01;
        end else if ((kind_q != KIND_R) && imm_bad) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b10;
        end else if ((kind_q == KIND_R) && f7_bad) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b11;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = enc_word;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_we_d    = 1'b0;
          word_done_d = 1'b1;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          count_d     = count_q + (ADDR_W+1)'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush drops whatever is in flight, including any pulse about to fire.
    if (flush) begin
      state_d     = S_IDLE;
      mem_we_d    = 1'b0;
      wr_ptr_d    = '0;
      count_d     = '0;
      word_done_d = 1'b0;
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      imm_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      word_done_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      f3_q        <= f3_d;
      f7_q        <= f7_d;
      imm_q       <= imm_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      word_done_q <= word_done_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_done = word_done_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign count     = count_q;
  assign full      = full_w;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes/errors,
// a monitor pops and compares whenever the DUT presents a write or an error.
module tb_instr_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_kind = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic              word_done;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;
  logic              full;

  typedef struct {
    bit                is_err;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [1:0]        code;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [ADDR_W-1:0] exp_ptr = '0;
  logic [ADDR_W:0]   exp_count = '0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .word_done(word_done),
    .err_valid(err_valid), .err_code(err_code),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per new write and per error pulse.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_we = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_we  = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (mem_we) begin
        if (!prev_we) begin
          if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_write", 32'd1, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            checkOutput("sb_kind_write", {31'd0, cur.is_err}, 32'd0);
          end
        end
        if (have_cur) begin
          checkOutput("sb_wr_addr", {30'd0, mem_addr}, {30'd0, cur.addr});
          checkOutput("sb_wr_data", mem_wdata, cur.data);
        end
      end
      if (err_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_err", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("sb_kind_err", {31'd0, e.is_err}, 32'd1);
          checkOutput("sb_err_code", {30'd0, err_code}, {30'd0, e.code});
        end
      end
      prev_we = mem_we;
    end
  end

  task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input bit push, input bit is_err,
                               input logic [1:0] code, input logic [31:0] data);
    int n;
    exp_t e;
    @(negedge clk);
    in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.is_err = is_err; e.addr = exp_ptr; e.data = data; e.code = code;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ackWrite(input int stall);
    int n;
    n = 0;
    while (!mem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_we) begin
      checkOutput("we_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_we", {31'd0, mem_we}, 32'd1);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_ptr = exp_ptr + 1'b1;
    exp_count = exp_count + 1'b1;
    checkOutput("word_done", {31'd0, word_done}, 32'd1);
    checkOutput("we_drop", {31'd0, mem_we}, 32'd0);
    checkOutput("count", {29'd0, count}, {29'd0, exp_count});
    @(negedge clk);
    checkOutput("word_done_single", {31'd0, word_done}, 32'd0);
  endtask

  task automatic expectReject();
    repeat (2) @(negedge clk);
    checkOutput("rej_no_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rej_count", {29'd0, count}, {29'd0, exp_count});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({tag, "_addr"}, {30'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, word_done}, 32'd0);
    checkOutput({tag, "_errv"}, {31'd0, err_valid}, 32'd0);
    checkOutput({tag, "_errc"}, {30'd0, err_code}, 32'd0);
    checkOutput({tag, "_count"}, {29'd0, count}, 32'd0);
    checkOutput({tag, "_full"}, {31'd0, full}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkResetValues("reset");

    // Legal words: add, lw with negative imm, sw
    applyStimulus(2'b00, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1, 0, 2'b00, 32'h002081B3);
    ackWrite(0);
    applyStimulus(2'b01, 5'd5, 5'd2, 5'd0, 3'b010, 7'h00, 32'hFFFFFFFC, 1, 0, 2'b00, 32'hFFC12283);
    ackWrite(0);
    applyStimulus(2'b10, 5'd0, 5'd2, 5'd5, 3'b010, 7'h00, 32'd8, 1, 0, 2'b00, 32'h00512423);
    ackWrite(0);

    // Rejects
    applyStimulus(2'b01, 5'd5, 5'd2, 5'd0, 3'b010, 7'h00, 32'd2048, 1, 1, 2'b10, 32'd0);
    expectReject();
    applyStimulus(2'b11, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0, 1, 1, 2'b01, 32'd0);
    expectReject();
    applyStimulus(2'b00, 5'd3, 5'd1, 5'd2, 3'b000, 7'h01, 32'd0, 1, 1, 2'b11, 32'd0);
    expectReject();

    // sub x7,x3,x4 with a 5-cycle ack stall fills the 4-word memory
    applyStimulus(2'b00, 5'd7, 5'd3, 5'd4, 3'b000, 7'h20, 32'd0, 1, 0, 2'b00, 32'h404183B3);
    ackWrite(5);
    checkOutput("full_set", {31'd0, full}, 32'd1);

    @(negedge clk);
    in_kind = 2'b00; in_funct7 = 7'h00; in_valid = 1'b1;
    repeat (3) begin
      checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    flush = 1'b1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    exp_ptr = '0;
    exp_count = '0;
    checkOutput("flush_count", {29'd0, count}, 32'd0);
    checkOutput("flush_full", {31'd0, full}, 32'd0);

    // Immediate boundaries after flush: -2048 and 2047 legal, -2049 rejected
    applyStimulus(2'b01, 5'd1, 5'd0, 5'd0, 3'b010, 7'h00, 32'hFFFFF800, 1, 0, 2'b00, 32'h80002083);
    ackWrite(0);
    applyStimulus(2'b10, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd2047, 1, 0, 2'b00, 32'h7E20AFA3);
    ackWrite(0);
    applyStimulus(2'b10, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'hFFFFF7FF, 1, 1, 2'b10, 32'd0);
    expectReject();

    // Flush while the write is pending
    applyStimulus(2'b00, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1, 0, 2'b00, 32'h002081B3);
    @(negedge clk);
    checkOutput("pre_flush_we", {31'd0, mem_we}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_ptr = '0;
    exp_count = '0;
    checkOutput("wflush_we", {31'd0, mem_we}, 32'd0);
    checkOutput("wflush_count", {29'd0, count}, 32'd0);
    checkOutput("wflush_done", {31'd0, word_done}, 32'd0);
    @(negedge clk);
    checkOutput("wflush_done2", {31'd0, word_done}, 32'd0);

    // Reset while a reserved-kind request sits in CHECK: no error pulse
    applyStimulus(2'b11, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0, 0, 0, 2'b00, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetValues("rstchk");
    @(negedge clk);
    checkOutput("rstchk_errv2", {31'd0, err_valid}, 32'd0);

    applyStimulus(2'b00, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1, 0, 2'b00, 32'h002081B3);
    ackWrite(0);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
